controller_num_entry: RTL and testbench
=======================================

Name: controller_num_entry

Overview:
Parametrised keypad number-entry unit for the calculator controller. It builds a multi-digit operand from keypad digit and edit commands in a BCD shift buffer, which also drives the display. On commit, a multi-cycle FSM converts the buffer to a signed two's-complement binary operand and presents it to the CPU-side datapath with a one-cycle valid pulse.

Parameters:
DIGITS, 8, maximum number of decimal digits held (1..16)
DATA_W, 32, width of the binary operand output (8..64)
CNT_W, $clog2(DIGITS+1), width of the digit counter (derived; do not override)

Ports:
Clock  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-low reset
in_valid  input  1  edit command present
in_ready  output  1  unit can accept a command
in_op  input  3  0=DIGIT, 1=BKSP, 2=CLEAR, 3=NEG, 4=COMMIT; 5..7 reserved
in_digit  input  4  digit value for DIGIT
busy  output  1  conversion in progress
bcd_Q  output  4*DIGITS  entry buffer; nibble 0 = least significant digit
count_Q  output  CNT_W  number of significant digits entered
neg_Q  output  1  entry sign flag
num_valid  output  1  one-cycle pulse: num_data and num_ovf are fresh
num_data  output  DATA_W  converted signed operand; held until the next conversion
num_ovf  output  1  operand not representable in DATA_W bits; held with num_data

Behaviour:
- Reset (Reset==0 at a clock edge): state=ENTRY; bcd_Q=0, count_Q=0, neg_Q=0, num_valid=0, num_data=0, num_ovf=0, busy=0. Reset during CONVERT aborts the conversion; no num_valid is produced.
- States: ENTRY, CONVERT, DONE. in_ready=1 only in ENTRY. busy=1 in CONVERT and DONE.
- Accept = in_valid & in_ready. Commands are processed in the accept cycle; results are visible the next cycle.
- DIGIT: in_digit>9 is ignored. If count_Q==DIGITS, the command is ignored (buffer full, no wrap). If count_Q==0 and in_digit==0, the buffer stays 0 and count stays 0 (leading-zero suppression). Otherwise bcd_Q shifts left one nibble, in_digit is inserted at nibble 0, and count_Q increments.
- BKSP: if count_Q>0, bcd_Q shifts right one nibble with zero fill and count_Q decrements; otherwise no effect. neg_Q is unchanged.
- CLEAR: bcd_Q=0, count_Q=0, neg_Q=0.
- NEG: neg_Q toggles. See optional feature.
- Reserved ops: accepted and ignored.
- COMMIT: ENTRY -> CONVERT. Initialise acc=0, idx=DIGITS-1, ovf=0.
- CONVERT: exactly one nibble per cycle, MS first: acc = acc*10 + bcd_Q[idx]. acc is DATA_W+1 bits. ovf is sticky and sets when the product or sum exceeds the acc range. After idx=0 is processed -> DONE. Duration is always DIGITS cycles, regardless of count_Q.
- DONE, single cycle:
  - num_data = neg_Q ? -acc : acc, truncated to DATA_W bits.
  - num_ovf = ovf | (acc > 2^(DATA_W-1)-1 when positive) | (acc > 2^(DATA_W-1) when negative).
  - num_valid=1 for this cycle only.
  - bcd_Q, count_Q and neg_Q clear.
  - Transition -> ENTRY.
- Latency: COMMIT accepted at edge t -> num_valid high in cycle t+DIGITS+1. in_ready returns the cycle after the num_valid pulse.
- A COMMIT with count_Q==0 converts to 0; with neg_Q=1 it yields 0 (-0 = 0, no overflow).
- num_valid is never asserted outside DONE.

Optional Feature:
NUM_ENTRY_NEG_EN. When defined, NEG toggles neg_Q and negative operands are produced as described above. When undefined:
- NEG is treated as a reserved op (accepted, ignored).
- neg_Q is tied to 0.
- The negation path and the negative-limit overflow check are removed.
- num_data is always non-negative and num_ovf flags acc > 2^(DATA_W-1)-1.

Test Plan:
1. Defaults: digits 1,2,3 then COMMIT -> bcd_Q=0x00000123, count_Q=3, then num_valid exactly 9 cycles after the commit edge with num_data=123, num_ovf=0.
2. Digits 0,0,5 -> count_Q=1, bcd_Q=0x5; then BKSP twice -> count_Q=0, bcd_Q=0; then DIGIT 12 -> ignored.
3. Nine digits 9 with DIGITS=8 -> 9th ignored, count_Q=8; COMMIT -> num_data=99999999, num_ovf=0; in_valid held during busy -> no commands accepted.
4. DATA_W=16 (NUM_ENTRY_NEG_EN defined): 32768 with NEG -> num_data=16'h8000, num_ovf=0; 32768 positive -> num_ovf=1; 40000 with NEG -> num_ovf=1.
5. Digits 4,2 then NEG, COMMIT -> num_data=-42 (0xFFFFFFD6), and after DONE: neg_Q=0, count_Q=0.
6. Reset asserted mid-CONVERT -> no num_valid ever appears; all outputs return to reset values the next cycle; in_ready=1.

Source files
------------

// File: rtl/controller_num_entry.sv
// Keypad number-entry unit: BCD entry buffer plus a digit-serial BCD-to-binary converter.
// Optional macro NUM_ENTRY_NEG_EN enables the sign toggle and negative operand output.
module controller_num_entry #(
    parameter int DIGITS = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [3:0]            in_digit,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_Q,
    output logic [CNT_W-1:0]      count_Q,
    output logic                  neg_Q,
    output logic                  num_valid,
    output logic [DATA_W-1:0]     num_data,
    output logic                  num_ovf
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [2:0] OP_DIGIT  = 3'd0;
    localparam logic [2:0] OP_BKSP   = 3'd1;
    localparam logic [2:0] OP_CLEAR  = 3'd2;
`ifdef NUM_ENTRY_NEG_EN
    localparam logic [2:0] OP_NEG    = 3'd3;
    localparam logic [DATA_W:0] NEG_LIM = {2'b01, {(DATA_W-1){1'b0}}};
`endif
    localparam logic [2:0] OP_COMMIT = 3'd4;

    localparam logic [CNT_W-1:0]  FULL    = CNT_W'(DIGITS);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DIGITS - 1);
    localparam logic [DATA_W+4:0] TEN     = (DATA_W+5)'(10);
    localparam logic [DATA_W:0]   POS_LIM = {2'b00, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {ENTRY, CONVERT, DONE} state_t;

    state_t              state;
    logic [DATA_W:0]     acc;
    logic                ovf;
    logic [IDX_W-1:0]    idx;

    logic                accept;
    logic [3:0]          nib;
    logic [DATA_W+4:0]   sum;
    logic [DATA_W:0]     acc_next;
    logic                ovf_next;
    logic [4*DIGITS-1:0] shifted;
    logic [DATA_W-1:0]   fin_data;
    logic                fin_ovf;

    assign in_ready = (state == ENTRY);
    assign busy     = (state != ENTRY);
    assign accept   = in_valid & in_ready;

    // The result is formed on the last CONVERT edge so num_valid is high exactly during DONE.
    always_comb begin
        nib      = bcd_Q[4*int'(idx) +: 4];
        sum      = ({4'b0000, acc} * TEN) + {{(DATA_W+1){1'b0}}, nib};
        acc_next = sum[DATA_W:0];
        ovf_next = ovf | (|sum[DATA_W+4:DATA_W+1]);
        shifted       = bcd_Q << 4;
        shifted[3:0]  = in_digit;
`ifdef NUM_ENTRY_NEG_EN
        fin_data = neg_Q ? -acc_next[DATA_W-1:0] : acc_next[DATA_W-1:0];
        fin_ovf  = ovf_next | (neg_Q ? (acc_next > NEG_LIM) : (acc_next > POS_LIM));
`else
        fin_data = acc_next[DATA_W-1:0];
        fin_ovf  = ovf_next | (acc_next > POS_LIM);
`endif
    end

`ifndef NUM_ENTRY_NEG_EN
    assign neg_Q = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= ENTRY;
            bcd_Q     <= '0;
            count_Q   <= '0;
`ifdef NUM_ENTRY_NEG_EN
            neg_Q     <= 1'b0;
`endif
            num_valid <= 1'b0;
            num_data  <= '0;
            num_ovf   <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                ENTRY: begin
                    if (accept) begin
                        case (in_op)
                            OP_DIGIT: begin
                                if (in_digit <= 4'd9 && count_Q != FULL &&
                                    !(count_Q == '0 && in_digit == 4'd0)) begin
                                    bcd_Q   <= shifted;
                                    count_Q <= count_Q + 1'b1;
                                end
                            end
                            OP_BKSP: begin
                                if (count_Q != '0) begin
                                    bcd_Q   <= bcd_Q >> 4;
                                    count_Q <= count_Q - 1'b1;
                                end
                            end
                            OP_CLEAR: begin
                                bcd_Q   <= '0;
                                count_Q <= '0;
`ifdef NUM_ENTRY_NEG_EN
                                neg_Q   <= 1'b0;
`endif
                            end
`ifdef NUM_ENTRY_NEG_EN
                            OP_NEG: neg_Q <= ~neg_Q;
`endif
                            OP_COMMIT: begin
                                state <= CONVERT;
                                acc   <= '0;
                                idx   <= IDX_MAX;
                                ovf   <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                CONVERT: begin
                    acc <= acc_next;
                    ovf <= ovf_next;
                    if (idx == '0) begin
                        state     <= DONE;
                        num_valid <= 1'b1;
                        num_data  <= fin_data;
                        num_ovf   <= fin_ovf;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    num_valid <= 1'b0;
                    bcd_Q     <= '0;
                    count_Q   <= '0;
`ifdef NUM_ENTRY_NEG_EN
                    neg_Q     <= 1'b0;
`endif
                    state     <= ENTRY;
                end
                default: state <= ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_controller_num_entry.sv
// Bench for controller_num_entry: a 32-bit and a 16-bit instance share one command stream
// and are compared against a digit-list reference model.
module tb_controller_num_entry;

    logic        Clock;
    logic        Reset;
    logic        in_valid;
    logic [2:0]  in_op;
    logic [3:0]  in_digit;

    logic        in_ready, busy, neg_Q, num_valid, num_ovf;
    logic [31:0] bcd_Q;
    logic [3:0]  count_Q;
    logic [31:0] num_data;

    logic        w16_in_ready, w16_busy, w16_neg_Q, w16_num_valid, w16_num_ovf;
    logic [31:0] w16_bcd_Q;
    logic [3:0]  w16_count_Q;
    logic [15:0] w16_num_data;

    int checks = 0;
    int errors = 0;

    int q[$];
    bit modelNeg = 1'b0;
`ifdef NUM_ENTRY_NEG_EN
    bit negEn = 1'b1;
`else
    bit negEn = 1'b0;
`endif

    controller_num_entry #(.DIGITS(8), .DATA_W(32)) dut (
        .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_digit(in_digit), .busy(busy), .bcd_Q(bcd_Q),
        .count_Q(count_Q), .neg_Q(neg_Q), .num_valid(num_valid),
        .num_data(num_data), .num_ovf(num_ovf)
    );

    controller_num_entry #(.DIGITS(8), .DATA_W(16)) dut16 (
        .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(w16_in_ready),
        .in_op(in_op), .in_digit(in_digit), .busy(w16_busy), .bcd_Q(w16_bcd_Q),
        .count_Q(w16_count_Q), .neg_Q(w16_neg_Q), .num_valid(w16_num_valid),
        .num_data(w16_num_data), .num_ovf(w16_num_ovf)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic longint modelValue();
        longint v = 0;
        foreach (q[i]) v = v * 10 + longint'(q[i]);
        return v;
    endfunction

    function automatic logic [63:0] modelBcd();
        logic [63:0] b = '0;
        foreach (q[i]) b = (b << 4) | 64'(q[i]);
        return b;
    endfunction

    // Keypad rules expressed on a most-significant-first digit list.
    task automatic modelCmd(input int op, input int dig);
        case (op)
            0: if (dig <= 9 && q.size() < 8 && !(q.size() == 0 && dig == 0)) q.push_back(dig);
            1: if (q.size() > 0) void'(q.pop_back());
            2: begin q.delete(); modelNeg = 1'b0; end
            3: if (negEn) modelNeg = ~modelNeg;
            default: ;
        endcase
    endtask

    task automatic applyStimulus(input int op, input int dig);
        @(negedge Clock);
        in_valid = 1'b1;
        in_op    = 3'(op);
        in_digit = 4'(dig);
        @(posedge Clock);
        #1;
        in_valid = 1'b0;
        modelCmd(op, dig);
    endtask

    task automatic checkEntry(input string tag);
        checkOutput({tag, " bcd"},   64'(bcd_Q),       modelBcd());
        checkOutput({tag, " count"}, 64'(count_Q),     64'(q.size()));
        checkOutput({tag, " neg"},   64'(neg_Q),       64'(modelNeg));
        checkOutput({tag, " bcd16"}, 64'(w16_bcd_Q),   modelBcd());
        checkOutput({tag, " cnt16"}, 64'(w16_count_Q), 64'(q.size()));
    endtask

    task automatic commitAndCheck(input string tag, input bit holdValid);
        longint      v = modelValue();
        bit          n = modelNeg;
        longint      s;
        logic [63:0] exp32, exp16;
        bit          ovf32, ovf16;
        s     = n ? -v : v;
        exp32 = {32'b0, s[31:0]};
        exp16 = {48'b0, s[15:0]};
        ovf32 = n ? (v > 64'd2147483648) : (v > 64'd2147483647);
        ovf16 = n ? (v > 64'd32768) : (v > 64'd32767);
        applyStimulus(4, 0);
        if (holdValid) begin
            in_valid = 1'b1;
            in_op    = 3'd0;
            in_digit = 4'd7;
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge Clock);
            #1;
            if (k == 8) in_valid = 1'b0;
            checkOutput({tag, " valid"},   64'(num_valid),     64'(k == 8));
            checkOutput({tag, " valid16"}, 64'(w16_num_valid), 64'(k == 8));
            checkOutput({tag, " ready"},   64'(in_ready),      64'd0);
            checkOutput({tag, " busy"},    64'(busy),          64'd1);
        end
        checkOutput({tag, " data"},   64'(num_data),     exp32);
        checkOutput({tag, " ovf"},    64'(num_ovf),      64'(ovf32));
        checkOutput({tag, " data16"}, 64'(w16_num_data), exp16);
        checkOutput({tag, " ovf16"},  64'(w16_num_ovf),  64'(ovf16));
        q.delete();
        modelNeg = 1'b0;
        @(posedge Clock);
        #1;
        checkOutput({tag, " post ready"}, 64'(in_ready),  64'd1);
        checkOutput({tag, " post busy"},  64'(busy),      64'd0);
        checkOutput({tag, " post valid"}, 64'(num_valid), 64'd0);
        checkOutput({tag, " held data"},  64'(num_data),  exp32);
        checkEntry({tag, " post"});
    endtask

    initial begin
        Reset    = 1'b0;
        in_valid = 1'b0;
        in_op    = 3'd0;
        in_digit = 4'd0;
        repeat (2) @(posedge Clock);
        #1;
        checkOutput("rst ready", 64'(in_ready),  64'd1);
        checkOutput("rst busy",  64'(busy),      64'd0);
        checkOutput("rst valid", 64'(num_valid), 64'd0);
        checkOutput("rst data",  64'(num_data),  64'd0);
        checkOutput("rst ovf",   64'(num_ovf),   64'd0);
        checkEntry("rst");
        Reset = 1'b1;

        applyStimulus(0, 1); applyStimulus(0, 2); applyStimulus(0, 3);
        checkOutput("t1 bcd const", 64'(bcd_Q), 64'h123);
        checkEntry("t1");
        commitAndCheck("t1", 1'b0);

        applyStimulus(0, 0); applyStimulus(0, 0); applyStimulus(0, 5);
        checkOutput("t2 bcd const", 64'(bcd_Q), 64'h5);
        checkEntry("t2 digits");
        applyStimulus(1, 0); applyStimulus(1, 0);
        checkEntry("t2 bksp");
        applyStimulus(0, 12);
        checkEntry("t2 bad digit");

        for (int i = 0; i < 9; i++) applyStimulus(0, 9);
        checkOutput("t3 count const", 64'(count_Q), 64'd8);
        checkEntry("t3 full");
        commitAndCheck("t3", 1'b1);

        applyStimulus(0, 3); applyStimulus(0, 2); applyStimulus(0, 7);
        applyStimulus(0, 6); applyStimulus(0, 8); applyStimulus(3, 0);
        commitAndCheck("t4 neg32768", 1'b0);
        applyStimulus(0, 3); applyStimulus(0, 2); applyStimulus(0, 7);
        applyStimulus(0, 6); applyStimulus(0, 8);
        commitAndCheck("t4 pos32768", 1'b0);
        applyStimulus(0, 4); for (int i = 0; i < 4; i++) applyStimulus(0, 0);
        applyStimulus(3, 0);
        commitAndCheck("t4 neg40000", 1'b0);

        applyStimulus(0, 4); applyStimulus(0, 2); applyStimulus(3, 0);
        checkEntry("t5");
        commitAndCheck("t5", 1'b0);

        applyStimulus(3, 0);
        commitAndCheck("neg zero", 1'b0);

        for (int i = 0; i < 80; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 50)       applyStimulus(0, $urandom_range(0, 11));
            else if (r < 62)  applyStimulus(1, 0);
            else if (r < 66)  applyStimulus(2, 0);
            else if (r < 76)  applyStimulus(3, 0);
            else if (r < 82)  applyStimulus($urandom_range(5, 7), $urandom_range(0, 15));
            if (r >= 82) commitAndCheck("rand commit", 1'b0);
            else         checkEntry("rand");
        end

        applyStimulus(0, 7); applyStimulus(0, 7);
        applyStimulus(4, 0);
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        q.delete();
        modelNeg = 1'b0;
        checkOutput("t6 ready", 64'(in_ready),  64'd1);
        checkOutput("t6 busy",  64'(busy),      64'd0);
        checkOutput("t6 data",  64'(num_data),  64'd0);
        checkOutput("t6 ovf",   64'(num_ovf),   64'd0);
        checkEntry("t6");
        for (int k = 0; k < 12; k++) begin
            @(posedge Clock);
            #1;
            checkOutput("t6 no valid",   64'(num_valid),     64'd0);
            checkOutput("t6 no valid16", 64'(w16_num_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
